// File: rtl/dff_bist_driver_if.sv
// DUT-side bundle: the driver owns rst/d, the flip-flop under test returns q/qbar.
`timescale 1ns/1ps
interface dff_bist_driver_if #(
  parameter int unsigned WIDTH = 1
);
  logic             dut_rst;
  logic [WIDTH-1:0] dut_d;
  logic [WIDTH-1:0] dut_q;
  logic [WIDTH-1:0] dut_qbar;

  modport master (
    output dut_rst,
    output dut_d,
    input  dut_q,
    input  dut_qbar
  );

  modport slave (
    input  dut_rst,
    input  dut_d,
    output dut_q,
    output dut_qbar
  );
endinterface

// File: rtl/dff_bist_driver.sv
// Stimulus generator and self-checker for a D flip-flop with synchronous reset.
// Drives an LFSR pattern with a reset phase and one mid-run reset, compares q
// against a one-cycle-delayed model and checks q/qbar complementarity.
`timescale 1ns/1ps
module dff_bist_driver #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned NUM_VECTORS = 64,
  parameter int unsigned RST_CYCLES  = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  dff_bist_driver_if.master  dut_io,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [CNT_W-1:0]   err_count_o,
  output logic [CNT_W-1:0]   first_err_idx_o,
  output logic [1:0]         err_type_o
);

  localparam logic [15:0] SeedEff   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int unsigned NumChecks = RST_CYCLES + NUM_VECTORS;
  localparam logic [15:0] RstLast   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] RunLast   = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] MidRun    = 16'(NUM_VECTORS / 2);
  localparam logic [15:0] ChkLast   = 16'(NumChecks - 1);

  typedef enum logic [2:0] {StIdle, StRstph, StRun, StDrain, StDone} state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  // Runs one step ahead of dut_d: holds the state for the next drive cycle.
  logic [15:0]        lfsr_q, lfsr_d;
  logic               dut_rst_q, dut_rst_d;
  logic [WIDTH-1:0]   dut_d_q, dut_d_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic               drv_q, drv_d;
  logic [15:0]        chk_idx_q, chk_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic [1:0]         err_type_q, err_type_d;
  logic               q_fail, qbar_fail;

  // Next-state: checker pipeline first, then the drive sequencer.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    lfsr_d          = lfsr_q;
    dut_rst_d       = dut_rst_q;
    dut_d_d         = dut_d_q;
    busy_d          = busy_q;
    done_d          = done_q;
    pass_d          = pass_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    err_type_d      = err_type_q;
    chk_idx_d       = chk_idx_q;
    q_fail          = 1'b0;
    qbar_fail       = 1'b0;
    // exp_q mirrors what an ideal DFF captures from the values presented this cycle.
    exp_d           = dut_rst_q ? '0 : dut_d_q;
    drv_d           = (state_q == StRstph) || (state_q == StRun);

    // drv_q set means the q seen now answers a drive cycle; never true in IDLE/DONE.
    if (drv_q) begin
      q_fail    = (dut_io.dut_q != exp_q);
      qbar_fail = |(~(dut_io.dut_q ^ dut_io.dut_qbar));
      if (q_fail || qbar_fail) begin
        if (err_count_q != '1) begin
          err_count_d = err_count_q + CNT_W'(1);
        end
        if (err_count_q == '0) begin
          first_err_idx_d = CNT_W'(chk_idx_q);
          err_type_d      = {qbar_fail, q_fail};
        end
      end
      chk_idx_d = chk_idx_q + 16'd1;
      if (chk_idx_q == ChkLast) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        pass_d = (err_count_d == '0);
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d         = StRstph;
          cnt_d           = '0;
          lfsr_d          = lfsr_next(SeedEff);
          dut_rst_d       = 1'b1;
          dut_d_d         = SeedEff[WIDTH-1:0];
          busy_d          = 1'b1;
          done_d          = 1'b0;
          pass_d          = 1'b0;
          err_count_d     = '0;
          first_err_idx_d = '0;
          err_type_d      = '0;
          chk_idx_d       = '0;
        end
      end
      StRstph: begin
        lfsr_d  = lfsr_next(lfsr_q);
        dut_d_d = lfsr_q[WIDTH-1:0];
        if (cnt_q == RstLast) begin
          state_d   = StRun;
          cnt_d     = '0;
          dut_rst_d = 1'b0;
        end else begin
          cnt_d     = cnt_q + 16'd1;
          dut_rst_d = 1'b1;
        end
      end
      StRun: begin
        if (cnt_q == RunLast) begin
          state_d   = StDrain;
          cnt_d     = '0;
          dut_rst_d = 1'b0;
        end else begin
          cnt_d     = cnt_q + 16'd1;
          lfsr_d    = lfsr_next(lfsr_q);
          dut_d_d   = lfsr_q[WIDTH-1:0];
          // Single mid-run reset pulse exercises reset after real data.
          dut_rst_d = ((cnt_q + 16'd1) == MidRun);
        end
      end
      StDrain: begin
        if (cnt_q == 16'd1) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      lfsr_q          <= SeedEff;
      dut_rst_q       <= 1'b1;
      dut_d_q         <= '0;
      exp_q           <= '0;
      drv_q           <= 1'b0;
      chk_idx_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      err_type_q      <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      lfsr_q          <= lfsr_d;
      dut_rst_q       <= dut_rst_d;
      dut_d_q         <= dut_d_d;
      exp_q           <= exp_d;
      drv_q           <= drv_d;
      chk_idx_q       <= chk_idx_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      err_type_q      <= err_type_d;
    end
  end

  assign dut_io.dut_rst  = dut_rst_q;
  assign dut_io.dut_d    = dut_d_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_count_o     = err_count_q;
  assign first_err_idx_o = first_err_idx_q;
  assign err_type_o      = err_type_q;

endmodule
